// File: rtl/alpharetz_alu_issue.sv
// Issue stage in front of the ALU: a two-entry FIFO (head + skid) with
// writeback forwarding applied both at enqueue and to held entries.
module alpharetz_alu_issue #(
    parameter int CPU_DATA_WIDTH  = 32,
    parameter int OPCODE_WIDTH    = 4,
    parameter int SHORT_IMM_WIDTH = 5,
    parameter int REG_ADDR_WIDTH  = 5
) (
    input  logic                       clk,
    input  logic                       sync_rst,
    input  logic                       clk_en,
    input  logic                       sys_en,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OPCODE_WIDTH-1:0]    in_opcode,
    input  logic [OPCODE_WIDTH-1:0]    in_funct,
    input  logic [SHORT_IMM_WIDTH-1:0] in_s_imm,
    input  logic                       in_use_carry,
    input  logic [REG_ADDR_WIDTH-1:0]  in_rs1,
    input  logic [REG_ADDR_WIDTH-1:0]  in_rs2,
    input  logic [REG_ADDR_WIDTH-1:0]  in_rd,
    input  logic [CPU_DATA_WIDTH-1:0]  in_src_1,
    input  logic [CPU_DATA_WIDTH-1:0]  in_src_2,
    input  logic                       fwd_valid,
    input  logic [REG_ADDR_WIDTH-1:0]  fwd_rd,
    input  logic [CPU_DATA_WIDTH-1:0]  fwd_data,
    input  logic                       flag_carry,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OPCODE_WIDTH-1:0]    opcode,
    output logic [OPCODE_WIDTH-1:0]    funct_code,
    output logic [SHORT_IMM_WIDTH-1:0] s_imm,
    output logic                       carry_in,
    output logic [CPU_DATA_WIDTH-1:0]  src_1,
    output logic [CPU_DATA_WIDTH-1:0]  src_2,
    output logic [REG_ADDR_WIDTH-1:0]  out_rd
);

    typedef struct packed {
        logic [OPCODE_WIDTH-1:0]    opcode;
        logic [OPCODE_WIDTH-1:0]    funct;
        logic [SHORT_IMM_WIDTH-1:0] s_imm;
        logic                       use_carry;
        logic [REG_ADDR_WIDTH-1:0]  rs1;
        logic [REG_ADDR_WIDTH-1:0]  rs2;
        logic [REG_ADDR_WIDTH-1:0]  rd;
        logic [CPU_DATA_WIDTH-1:0]  src1;
        logic [CPU_DATA_WIDTH-1:0]  src2;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;
    entry_t new_e, head_fwd, skid_fwd;
    logic   adv, enq, deq;

    // Register 0 is never forwarded: it must always read as zero.
    function automatic entry_t fwd_apply(entry_t e, logic fv,
                                         logic [REG_ADDR_WIDTH-1:0] frd,
                                         logic [CPU_DATA_WIDTH-1:0] fdata);
        entry_t r;
        r = e;
        if (fv && e.rs1 != '0 && e.rs1 == frd) r.src1 = fdata;
        if (fv && e.rs2 != '0 && e.rs2 == frd) r.src2 = fdata;
        return r;
    endfunction

    assign adv       = clk_en & sys_en & ~sync_rst;
    assign in_ready  = adv & (state_q != FULL);
    assign enq       = in_valid & in_ready;
    assign out_valid = (state_q != EMPTY);
    assign deq       = out_valid & out_ready & adv;

    always_comb begin
        new_e           = '0;
        new_e.opcode    = in_opcode;
        new_e.funct     = in_funct;
        new_e.s_imm     = in_s_imm;
        new_e.use_carry = in_use_carry;
        new_e.rs1       = in_rs1;
        new_e.rs2       = in_rs2;
        new_e.rd        = in_rd;
        new_e.src1      = (in_rs1 == '0) ? '0 : in_src_1;
        new_e.src2      = (in_rs2 == '0) ? '0 : in_src_2;
        new_e           = fwd_apply(new_e, fwd_valid, fwd_rd, fwd_data);
        head_fwd        = fwd_apply(head_q, fwd_valid, fwd_rd, fwd_data);
        skid_fwd        = fwd_apply(skid_q, fwd_valid, fwd_rd, fwd_data);
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (adv) begin
            if (flush) begin
                // Head payload is kept so outputs stay stable while invalid.
                state_d = EMPTY;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (enq) begin
                            head_d  = new_e;
                            state_d = ONE;
                        end
                    end
                    ONE: begin
                        if (enq && !deq) begin
                            head_d  = head_fwd;
                            skid_d  = new_e;
                            state_d = FULL;
                        end else if (enq && deq) begin
                            head_d  = new_e;
                        end else if (deq) begin
                            state_d = EMPTY;
                        end else begin
                            head_d  = head_fwd;
                        end
                    end
                    FULL: begin
                        if (deq) begin
                            head_d  = skid_fwd;
                            state_d = ONE;
                        end else begin
                            head_d  = head_fwd;
                            skid_d  = skid_fwd;
                        end
                    end
                    default: state_d = EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign opcode     = head_q.opcode;
    assign funct_code = head_q.funct;
    assign s_imm      = head_q.s_imm;
    assign src_1      = head_q.src1;
    assign src_2      = head_q.src2;
    assign out_rd     = head_q.rd;
    assign carry_in   = out_valid & head_q.use_carry & flag_carry;

endmodule

// File: tb/tb_alpharetz_alu_issue.sv
// Directed bench for the ALU issue stage: reset, streaming, backpressure,
// forwarding, carry, stall and flush.
module tb_alpharetz_alu_issue;

    logic        clk = 1'b0;
    logic        sync_rst, clk_en, sys_en, flush;
    logic        in_valid, in_ready;
    logic [3:0]  in_opcode, in_funct;
    logic [4:0]  in_s_imm;
    logic        in_use_carry;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic [31:0] in_src_1, in_src_2;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        flag_carry;
    logic        out_valid, out_ready;
    logic [3:0]  opcode, funct_code;
    logic [4:0]  s_imm;
    logic        carry_in;
    logic [31:0] src_1, src_2;
    logic [4:0]  out_rd;

    int n_chk = 0;
    int n_fail = 0;

    alpharetz_alu_issue dut (
        .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en), .sys_en(sys_en),
        .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct(in_funct), .in_s_imm(in_s_imm),
        .in_use_carry(in_use_carry), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rd(in_rd), .in_src_1(in_src_1), .in_src_2(in_src_2),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .flag_carry(flag_carry), .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .funct_code(funct_code), .s_imm(s_imm),
        .carry_in(carry_in), .src_1(src_1), .src_2(src_2), .out_rd(out_rd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic v, input logic [3:0] op, input logic uc,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] s1, input logic [31:0] s2);
        in_valid     = v;
        in_opcode    = op;
        in_funct     = op ^ 4'h5;
        in_s_imm     = 5'd3;
        in_use_carry = uc;
        in_rs1       = rs1;
        in_rs2       = rs2;
        in_rd        = 5'd9;
        in_src_1     = s1;
        in_src_2     = s2;
    endtask

    initial begin
        sync_rst = 1'b1; clk_en = 1'b1; sys_en = 1'b1; flush = 1'b0;
        fwd_valid = 1'b0; fwd_rd = '0; fwd_data = '0; flag_carry = 1'b0;
        out_ready = 1'b0;
        offer(1'b0, 4'h0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);

        // reset state
        tick(); tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_src_1", src_1, 32'h0);
        chk("rst_opcode", opcode, 4'h0);
        chk("rst_in_ready", in_ready, 1'b0);
        sync_rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // reset while FULL
        offer(1'b1, 4'h2, 1'b0, 5'd1, 5'd2, 32'hA1, 32'hA2);
        tick();
        offer(1'b1, 4'h3, 1'b0, 5'd1, 5'd2, 32'hB1, 32'hB2);
        tick();
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_head_src_1", src_1, 32'hA1);
        chk("full_head_opcode", opcode, 4'h2);
        chk("full_head_funct", funct_code, 4'h7);
        chk("full_head_rd", out_rd, 5'd9);
        chk("full_head_simm", s_imm, 5'd3);
        in_valid = 1'b0;
        sync_rst = 1'b1;
        #1;
        chk("rst_hi_in_ready", in_ready, 1'b0);
        tick();
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_src_1", src_1, 32'h0);
        chk("midrst_in_ready", in_ready, 1'b0);
        sync_rst = 1'b0;
        #1;
        chk("midrst_after_in_ready", in_ready, 1'b1);

        // back-to-back stream with out_ready high
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            offer(1'b1, 4'h1, 1'b0, 5'd1, 5'd2, 32'(i), 32'(2 * i));
            tick();
            chk("stream_valid", out_valid, 1'b1);
            chk("stream_src_1", src_1, 32'(i));
            chk("stream_src_2", src_2, 32'(2 * i));
            chk("stream_in_ready", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drain_valid", out_valid, 1'b0);

        // backpressure: A, B accepted, C held off until space opens
        out_ready = 1'b0;
        offer(1'b1, 4'h1, 1'b0, 5'd1, 5'd2, 32'h100, 32'h0);
        tick();
        offer(1'b1, 4'h1, 1'b0, 5'd1, 5'd2, 32'h200, 32'h0);
        tick();
        offer(1'b1, 4'h1, 1'b0, 5'd1, 5'd2, 32'h300, 32'h0);
        chk("bp_full_in_ready", in_ready, 1'b0);
        tick();
        chk("bp_head_a", src_1, 32'h100);
        out_ready = 1'b1;
        tick();
        chk("bp_head_b", src_1, 32'h200);
        chk("bp_one_in_ready", in_ready, 1'b1);
        tick();
        chk("bp_head_c", src_1, 32'h300);
        in_valid = 1'b0;
        tick();
        chk("bp_empty", out_valid, 1'b0);

        // forwarding at enqueue, rs=0 protection, held skid update
        out_ready = 1'b0;
        fwd_valid = 1'b1; fwd_rd = 5'd5; fwd_data = 32'hDEAD;
        offer(1'b1, 4'h1, 1'b0, 5'd5, 5'd3, 32'h11, 32'h22);
        tick();
        chk("fwd_enq_src_1", src_1, 32'hDEAD);
        chk("fwd_enq_src_2", src_2, 32'h22);
        fwd_rd = 5'd0; fwd_data = 32'h55;
        offer(1'b1, 4'h1, 1'b0, 5'd0, 5'd7, 32'h77, 32'h33);
        tick();
        in_valid = 1'b0;
        fwd_rd = 5'd7; fwd_data = 32'hBEEF;
        tick();
        fwd_valid = 1'b0;
        chk("fwd_head_keep_src_2", src_2, 32'h22);
        out_ready = 1'b1;
        tick();
        chk("fwd_zero_src_1", src_1, 32'h0);
        chk("fwd_skid_src_2", src_2, 32'hBEEF);
        tick();
        chk("fwd_empty", out_valid, 1'b0);

        // carry and clock-enable stall
        out_ready = 1'b0;
        flag_carry = 1'b1;
        offer(1'b1, 4'h2, 1'b1, 5'd1, 5'd2, 32'h33, 32'h0);
        tick();
        chk("carry_on", carry_in, 1'b1);
        flag_carry = 1'b0;
        #1;
        chk("carry_flag_off", carry_in, 1'b0);
        flag_carry = 1'b1;
        out_ready = 1'b1;
        offer(1'b1, 4'h2, 1'b0, 5'd1, 5'd2, 32'h44, 32'h0);
        tick();
        chk("carry_unused", carry_in, 1'b0);
        chk("carry_unused_src_1", src_1, 32'h44);
        in_valid = 1'b0;
        clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_src_1", src_1, 32'h44);
            chk("stall_in_ready", in_ready, 1'b0);
        end
        clk_en = 1'b1;
        tick();
        chk("stall_release_empty", out_valid, 1'b0);

        // flush from FULL with an offered op
        out_ready = 1'b0;
        offer(1'b1, 4'h1, 1'b0, 5'd1, 5'd2, 32'h501, 32'h0);
        tick();
        offer(1'b1, 4'h1, 1'b0, 5'd1, 5'd2, 32'h502, 32'h0);
        tick();
        offer(1'b1, 4'h1, 1'b0, 5'd1, 5'd2, 32'h503, 32'h0);
        flush = 1'b1;
        tick();
        chk("flush_full_valid", out_valid, 1'b0);
        chk("flush_full_in_ready", in_ready, 1'b1);
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("flush_full_stays_empty", out_valid, 1'b0);

        // flush from ONE with a simultaneous enqueue
        offer(1'b1, 4'h1, 1'b0, 5'd1, 5'd2, 32'h601, 32'h0);
        tick();
        offer(1'b1, 4'h1, 1'b0, 5'd1, 5'd2, 32'h602, 32'h0);
        flush = 1'b1;
        chk("flush_one_in_ready", in_ready, 1'b1);
        tick();
        chk("flush_one_valid", out_valid, 1'b0);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("flush_one_dropped", out_valid, 1'b0);
        offer(1'b1, 4'h1, 1'b0, 5'd1, 5'd2, 32'h700, 32'h0);
        tick();
        chk("post_flush_valid", out_valid, 1'b1);
        chk("post_flush_src_1", src_1, 32'h700);
        in_valid = 1'b0;
        tick();
        chk("final_empty", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alpharetz_alu_issue.md
Name: alpharetz_alu_issue

Overview:
Issue stage directly upstream of the ALU. It accepts decoded ALU operations with register-file operands from decode and buffers up to two of them in a FIFO-ordered skid buffer (head plus skid). It applies result forwarding from the writeback path, then presents the head entry to the ALU's opcode/funct_code/s_imm/src_1/src_2/carry_in inputs. A valid/ready handshake on both sides decouples decode from ALU stalls.

Parameters:
CPU_DATA_WIDTH, 32, operand/result width
OPCODE_WIDTH, 4, opcode and funct_code width
SHORT_IMM_WIDTH, 5, shift immediate width
REG_ADDR_WIDTH, 5, register index width; index 0 is the hardwired zero register

Ports:
clk  in  1  clock, all state on rising edge
sync_rst  in  1  synchronous active-high reset
clk_en  in  1  clock enable; stage advances only when clk_en & sys_en
sys_en  in  1  system enable
flush  in  1  discard all buffered entries
in_valid  in  1  decode offers an op
in_ready  out  1  stage accepts an op this cycle
in_opcode  in  OPCODE_WIDTH  ALU opcode
in_funct  in  OPCODE_WIDTH  function code
in_s_imm  in  SHORT_IMM_WIDTH  shift amount
in_use_carry  in  1  op consumes carry flag
in_rs1, in_rs2, in_rd  in  REG_ADDR_WIDTH  source/destination indices
in_src_1, in_src_2  in  CPU_DATA_WIDTH  register-file read data
fwd_valid  in  1  writeback result valid
fwd_rd  in  REG_ADDR_WIDTH  writeback destination
fwd_data  in  CPU_DATA_WIDTH  writeback data
flag_carry  in  1  current carry flag (flag_reg bit 1)
out_valid  out  1  head entry valid to ALU
out_ready  in  1  ALU/downstream consumes head
opcode, funct_code  out  OPCODE_WIDTH  to ALU
s_imm  out  SHORT_IMM_WIDTH  to ALU
carry_in  out  1  to ALU
src_1, src_2  out  CPU_DATA_WIDTH  to ALU
out_rd  out  REG_ADDR_WIDTH  destination index tagged with the op

Behaviour:
- Reset: sync_rst=1 at an edge clears all entries -> state EMPTY. All registered outputs are 0 (out_valid, opcode, funct_code, s_imm, src_1, src_2, out_rd). in_ready=0 while sync_rst is high. Reset overrides flush, enqueue and dequeue, including mid-transfer.
- adv = clk_en & sys_en & ~sync_rst.
- enq = in_valid & in_ready.
- deq = out_valid & out_ready & adv.
- States: EMPTY (0 entries), ONE (head only), FULL (head + skid).
- in_ready = adv & (state != FULL). Combinational from state, never from out_ready.
- Transitions:
  - EMPTY: enq -> ONE, entry loads head.
  - ONE: enq & ~deq -> FULL (entry to skid). enq & deq -> ONE (entry to head). deq only -> EMPTY.
  - FULL: deq -> ONE (skid moves to head). No enq is possible.
- Ordering is strict FIFO. The skid entry never bypasses the head.
- flush & adv: next state EMPTY and out_valid=0. A same-cycle enq is dropped (in_ready still asserted; decode must treat flush as squashing it). deq in the same cycle is still counted as consumed.
- No state change when adv=0; outputs hold.
- Operand resolution at enqueue, per source:
  - rsN==0 -> 0.
  - else fwd_valid & fwd_rd==rsN -> fwd_data.
  - else in_src_N.
- Held entries: every adv cycle, any held entry whose rsN matches fwd_rd (rsN!=0, fwd_valid) replaces that operand with fwd_data. This applies to the entry even in the cycle it is dequeued; the ALU sees the registered value, so the update lands on the next head.
- carry_in = out_valid & head.use_carry & flag_carry. Combinational; the only non-registered output path.
- out_* reflect the head entry. They are undefined-but-stable (retain last value) when out_valid=0, except carry_in, which is 0.
- Zero-bubble throughput: one op per cycle sustained when out_ready=1 continuously.

Test Plan:
- Reset mid-FULL: load two ops, assert sync_rst one cycle -> out_valid=0, src_1=0, in_ready=0 during reset, in_ready=1 the cycle after (adv=1).
- Back-to-back stream: 8 ops ADD (opcode 4'h1) src_1=i, src_2=2i, out_ready=1 -> out_valid continuous from cycle 1, src_2=2*src_1 each cycle, in order, state stays ONE.
- Backpressure: out_ready=0, offer 3 ops -> first two accepted (FULL), in_ready=0 on the third. Raise out_ready -> ops emerge in order A,B,C with no loss or duplicate.
- Forwarding: enq rs1=5, in_src_1=0x11 while fwd_valid=1, fwd_rd=5, fwd_data=0xDEAD -> src_1=0xDEAD. Enq rs1=0 with matching fwd_rd=0 -> src_1=0. Held skid entry rs2=7 sees fwd 7/0xBEEF -> src_2=0xBEEF at issue.
- Carry/stall: use_carry=1, flag_carry=1 -> carry_in=1. use_carry=0 -> 0. Drop clk_en for 3 cycles with out_ready=1 -> no dequeue, outputs held, in_ready=0.
- Flush with simultaneous enq in FULL and ONE -> next cycle out_valid=0, state EMPTY, flushed ops never presented.
